// File: rtl/int_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : int_issue_queue
// Brief    : Age-ordered integer issue queue with CDB wakeup and oldest-ready
//            select feeding the integer ALU over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module int_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                       Clk,
  input  logic                       Resetb,
  // dispatch write port
  input  logic                       Dispatch_en_Int,
  input  logic [3:0]                 Dispatch_Opcode,
  input  logic [4:0]                 Dispatch_Shfamt,
  input  logic                       Dispatch_Rs_Rdy,
  input  logic [31:0]                Dispatch_Rs_Data,
  input  logic [TAG_W-1:0]           Dispatch_Rs_Tag,
  input  logic                       Dispatch_Rt_Rdy,
  input  logic [31:0]                Dispatch_Rt_Data,
  input  logic [TAG_W-1:0]           Dispatch_Rt_Tag,
  input  logic [TAG_W-1:0]           Dispatch_Rd_Tag,
  output logic                       IssueQue_Full,
  // common data bus
  input  logic                       Cdb_Valid,
  input  logic [TAG_W-1:0]           Cdb_Tag,
  input  logic [31:0]                Cdb_Data,
  // issue port
  output logic                       Issue_Valid,
  input  logic                       Issue_Ready,
  output logic [3:0]                 Issue_Opcode,
  output logic [4:0]                 Issue_Shfamt,
  output logic [31:0]                Issue_Rs_Data,
  output logic [31:0]                Issue_Rt_Data,
  output logic [TAG_W-1:0]           Issue_Rd_Tag,
  output logic [$clog2(DEPTH):0]     IssueQue_Count
);

  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic             valid;
    logic [3:0]       opcode;
    logic [4:0]       shfamt;
    logic             rs_rdy;
    logic [31:0]      rs_data;
    logic [TAG_W-1:0] rs_tag;
    logic             rt_rdy;
    logic [31:0]      rt_data;
    logic [TAG_W-1:0] rt_tag;
    logic [TAG_W-1:0] rd_tag;
  } entry_t;

  entry_t               r_q   [DEPTH];
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_full;

  entry_t               w_cap [DEPTH];
  entry_t               w_up  [DEPTH];
  entry_t               w_nxt [DEPTH];
  logic [DEPTH-1:0]     w_shift;
  entry_t               w_new;
  logic                 w_any;
  logic [c_IDX_W-1:0]   w_sel;
  logic                 w_fire;
  logic                 w_accept;
  logic [c_CNT_W-1:0]   w_wr_ptr;
  logic [c_CNT_W-1:0]   w_cnt_nxt;

  // CDB snoop on stored entries; applied before compaction so a shifting
  // entry carries its capture with it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_cap[i] = r_q[i];
      if (Cdb_Valid && r_q[i].valid && !r_q[i].rs_rdy && (r_q[i].rs_tag == Cdb_Tag)) begin
        w_cap[i].rs_rdy  = 1'b1;
        w_cap[i].rs_data = Cdb_Data;
      end
      if (Cdb_Valid && r_q[i].valid && !r_q[i].rt_rdy && (r_q[i].rt_tag == Cdb_Tag)) begin
        w_cap[i].rt_rdy  = 1'b1;
        w_cap[i].rt_data = Cdb_Data;
      end
    end
  end

  // Oldest-ready select uses registered readiness only (no CDB bypass).
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_q[i].valid && r_q[i].rs_rdy && r_q[i].rt_rdy) begin
        w_any = 1'b1;
        w_sel = c_IDX_W'(i);
      end
    end
  end

  assign w_fire    = w_any & Issue_Ready;
  assign w_accept  = Dispatch_en_Int & ~r_full;
  assign w_wr_ptr  = r_count - c_CNT_W'(w_fire);
  assign w_cnt_nxt = r_count + c_CNT_W'(w_accept) - c_CNT_W'(w_fire);

  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.opcode  = Dispatch_Opcode;
    w_new.shfamt  = Dispatch_Shfamt;
    w_new.rs_rdy  = Dispatch_Rs_Rdy;
    w_new.rs_data = Dispatch_Rs_Data;
    w_new.rs_tag  = Dispatch_Rs_Tag;
    w_new.rt_rdy  = Dispatch_Rt_Rdy;
    w_new.rt_data = Dispatch_Rt_Data;
    w_new.rt_tag  = Dispatch_Rt_Tag;
    w_new.rd_tag  = Dispatch_Rd_Tag;
    if (Cdb_Valid && !Dispatch_Rs_Rdy && (Dispatch_Rs_Tag == Cdb_Tag)) begin
      w_new.rs_rdy  = 1'b1;
      w_new.rs_data = Cdb_Data;
    end
    if (Cdb_Valid && !Dispatch_Rt_Rdy && (Dispatch_Rt_Tag == Cdb_Tag)) begin
      w_new.rt_rdy  = 1'b1;
      w_new.rt_data = Cdb_Data;
    end
  end

  // Compaction: slots at or above the issued index take their upper neighbour.
  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    if (j < DEPTH - 1) begin : g_mid
      assign w_up[j] = w_cap[j+1];
    end else begin : g_top
      assign w_up[j] = '0;
    end

    assign w_shift[j] = w_fire && (j >= int'(w_sel));

    always_comb begin
      w_nxt[j] = w_shift[j] ? w_up[j] : w_cap[j];
      if (w_accept && (w_wr_ptr == c_CNT_W'(j)))
        w_nxt[j] = w_new;
    end
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      for (int i = 0; i < DEPTH; i++)
        r_q[i] <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        r_q[i] <= w_nxt[i];
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == c_CNT_W'(DEPTH));
    end
  end

  assign Issue_Valid    = w_any;
  assign Issue_Opcode   = w_any ? r_q[w_sel].opcode  : '0;
  assign Issue_Shfamt   = w_any ? r_q[w_sel].shfamt  : '0;
  assign Issue_Rs_Data  = w_any ? r_q[w_sel].rs_data : '0;
  assign Issue_Rt_Data  = w_any ? r_q[w_sel].rt_data : '0;
  assign Issue_Rd_Tag   = w_any ? r_q[w_sel].rd_tag  : '0;
  assign IssueQue_Full  = r_full;
  assign IssueQue_Count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_int_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_issue_queue
// Brief    : Scoreboard bench for int_issue_queue with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_issue_queue;

  logic        clk;
  logic        Resetb;
  logic        Dispatch_en_Int;
  logic [3:0]  Dispatch_Opcode;
  logic [4:0]  Dispatch_Shfamt;
  logic        Dispatch_Rs_Rdy;
  logic [31:0] Dispatch_Rs_Data;
  logic [5:0]  Dispatch_Rs_Tag;
  logic        Dispatch_Rt_Rdy;
  logic [31:0] Dispatch_Rt_Data;
  logic [5:0]  Dispatch_Rt_Tag;
  logic [5:0]  Dispatch_Rd_Tag;
  logic        IssueQue_Full;
  logic        Cdb_Valid;
  logic [5:0]  Cdb_Tag;
  logic [31:0] Cdb_Data;
  logic        Issue_Valid;
  logic        Issue_Ready;
  logic [3:0]  Issue_Opcode;
  logic [4:0]  Issue_Shfamt;
  logic [31:0] Issue_Rs_Data;
  logic [31:0] Issue_Rt_Data;
  logic [5:0]  Issue_Rd_Tag;
  logic [2:0]  IssueQue_Count;

  int_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (
    .Clk              (clk),
    .Resetb           (Resetb),
    .Dispatch_en_Int  (Dispatch_en_Int),
    .Dispatch_Opcode  (Dispatch_Opcode),
    .Dispatch_Shfamt  (Dispatch_Shfamt),
    .Dispatch_Rs_Rdy  (Dispatch_Rs_Rdy),
    .Dispatch_Rs_Data (Dispatch_Rs_Data),
    .Dispatch_Rs_Tag  (Dispatch_Rs_Tag),
    .Dispatch_Rt_Rdy  (Dispatch_Rt_Rdy),
    .Dispatch_Rt_Data (Dispatch_Rt_Data),
    .Dispatch_Rt_Tag  (Dispatch_Rt_Tag),
    .Dispatch_Rd_Tag  (Dispatch_Rd_Tag),
    .IssueQue_Full    (IssueQue_Full),
    .Cdb_Valid        (Cdb_Valid),
    .Cdb_Tag          (Cdb_Tag),
    .Cdb_Data         (Cdb_Data),
    .Issue_Valid      (Issue_Valid),
    .Issue_Ready      (Issue_Ready),
    .Issue_Opcode     (Issue_Opcode),
    .Issue_Shfamt     (Issue_Shfamt),
    .Issue_Rs_Data    (Issue_Rs_Data),
    .Issue_Rt_Data    (Issue_Rt_Data),
    .Issue_Rd_Tag     (Issue_Rd_Tag),
    .IssueQue_Count   (IssueQue_Count)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  sh;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [5:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Monitor: every negedge with valid&ready is one transfer at the next posedge.
  always @(negedge clk) begin
    if (Resetb && Issue_Valid && Issue_Ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_issue actual op=%0h rd=%0d required=no issue", Issue_Opcode, Issue_Rd_Tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (Issue_Opcode !== e.op || Issue_Shfamt !== e.sh || Issue_Rs_Data !== e.rs ||
            Issue_Rt_Data !== e.rt || Issue_Rd_Tag !== e.rd) begin
          bad++;
          $display("FAIL issue_fields actual op=%0h sh=%0d rs=%0h rt=%0h rd=%0d required op=%0h sh=%0d rs=%0h rt=%0h rd=%0d",
                   Issue_Opcode, Issue_Shfamt, Issue_Rs_Data, Issue_Rt_Data, Issue_Rd_Tag,
                   e.op, e.sh, e.rs, e.rt, e.rd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic disp(input logic [3:0] op, input logic [4:0] sh,
                      input logic rs_r, input logic [31:0] rs_d, input logic [5:0] rs_t,
                      input logic rt_r, input logic [31:0] rt_d, input logic [5:0] rt_t,
                      input logic [5:0] rd);
    Dispatch_en_Int  = 1'b1;
    Dispatch_Opcode  = op;
    Dispatch_Shfamt  = sh;
    Dispatch_Rs_Rdy  = rs_r;
    Dispatch_Rs_Data = rs_d;
    Dispatch_Rs_Tag  = rs_t;
    Dispatch_Rt_Rdy  = rt_r;
    Dispatch_Rt_Data = rt_d;
    Dispatch_Rt_Tag  = rt_t;
    Dispatch_Rd_Tag  = rd;
    tick();
    Dispatch_en_Int  = 1'b0;
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic [4:0] sh,
                              input logic [31:0] rs, input logic [31:0] rt, input logic [5:0] rd);
    exp_t e;
    e.op = op; e.sh = sh; e.rs = rs; e.rt = rt; e.rd = rd;
    return e;
  endfunction

  initial begin
    Resetb = 1'b0;
    Dispatch_en_Int = 1'b0; Dispatch_Opcode = '0; Dispatch_Shfamt = '0;
    Dispatch_Rs_Rdy = 1'b0; Dispatch_Rs_Data = '0; Dispatch_Rs_Tag = '0;
    Dispatch_Rt_Rdy = 1'b0; Dispatch_Rt_Data = '0; Dispatch_Rt_Tag = '0;
    Dispatch_Rd_Tag = '0;
    Cdb_Valid = 1'b0; Cdb_Tag = '0; Cdb_Data = '0;
    Issue_Ready = 1'b0;
    tick(); tick();
    chk("reset_valid", Issue_Valid, 0);
    chk("reset_full", IssueQue_Full, 0);
    chk("reset_count", IssueQue_Count, 0);
    chk("reset_rs_data", Issue_Rs_Data, 0);
    Resetb = 1'b1;
    tick();

    // Basic ADD issue
    Issue_Ready = 1'b1;
    sb.push_back(mk(4'h2, 5'd0, 32'd5, 32'd7, 6'd3));
    disp(4'h2, 5'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 6'd3);
    chk("add_valid", Issue_Valid, 1);
    tick();
    chk("add_count_after", IssueQue_Count, 0);
    chk("add_valid_after", Issue_Valid, 0);

    // SUB waits for rs tag 9
    disp(4'h6, 5'd0, 1'b0, 32'd0, 6'd9, 1'b1, 32'd1, 6'd0, 6'd10);
    chk("sub_wait0", Issue_Valid, 0);
    tick();
    chk("sub_wait1", Issue_Valid, 0);
    Cdb_Valid = 1'b1; Cdb_Tag = 6'd9; Cdb_Data = 32'h20;
    #1;
    chk("sub_no_bypass", Issue_Valid, 0);
    sb.push_back(mk(4'h6, 5'd0, 32'h20, 32'd1, 6'd10));
    tick();
    Cdb_Valid = 1'b0;
    chk("sub_woken", Issue_Valid, 1);
    tick();
    chk("sub_count_after", IssueQue_Count, 0);

    // Same-cycle forwarding into the dispatching entry
    Cdb_Valid = 1'b1; Cdb_Tag = 6'd4; Cdb_Data = 32'hAB;
    sb.push_back(mk(4'h2, 5'd0, 32'h11, 32'hAB, 6'd5));
    disp(4'h2, 5'd0, 1'b1, 32'h11, 6'd0, 1'b0, 32'd0, 6'd4, 6'd5);
    Cdb_Valid = 1'b0;
    chk("fwd_valid", Issue_Valid, 1);
    chk("fwd_rt_data", Issue_Rt_Data, 32'hAB);
    tick();
    chk("fwd_count_after", IssueQue_Count, 0);

    // Fill to full with issue stalled
    Issue_Ready = 1'b0;
    sb.push_back(mk(4'h0, 5'd0, 32'd1, 32'd2, 6'd20));
    disp(4'h0, 5'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 6'd20);
    sb.push_back(mk(4'h1, 5'd0, 32'd3, 32'd4, 6'd21));
    disp(4'h1, 5'd0, 1'b1, 32'd3, 6'd0, 1'b1, 32'd4, 6'd0, 6'd21);
    sb.push_back(mk(4'h2, 5'd0, 32'd5, 32'd6, 6'd22));
    disp(4'h2, 5'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd6, 6'd0, 6'd22);
    sb.push_back(mk(4'hC, 5'd0, 32'd7, 32'd8, 6'd23));
    disp(4'hC, 5'd0, 1'b1, 32'd7, 6'd0, 1'b1, 32'd8, 6'd0, 6'd23);
    chk("full_flag", IssueQue_Full, 1);
    chk("full_count", IssueQue_Count, 4);
    chk("full_hold_rd", Issue_Rd_Tag, 20);
    disp(4'h7, 5'd0, 1'b1, 32'd9, 6'd0, 1'b1, 32'd10, 6'd0, 6'd24);
    chk("full_ignore_count", IssueQue_Count, 4);
    // Issue and blocked dispatch in one edge: occupancy drops by one
    Issue_Ready = 1'b1;
    disp(4'h7, 5'd0, 1'b1, 32'd9, 6'd0, 1'b1, 32'd10, 6'd0, 6'd24);
    Issue_Ready = 1'b0;
    chk("full_issue_count", IssueQue_Count, 3);
    chk("full_issue_flag", IssueQue_Full, 0);
    Issue_Ready = 1'b1;
    tick(); tick(); tick();
    chk("drain_count", IssueQue_Count, 0);
    chk("drain_valid", Issue_Valid, 0);

    // Younger ready entry bypasses older pending one
    Issue_Ready = 1'b0;
    disp(4'h9, 5'd0, 1'b0, 32'd0, 6'd12, 1'b1, 32'h40, 6'd0, 6'd30);
    disp(4'h8, 5'd3, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 6'd31);
    chk("ooo_shfamt", Issue_Shfamt, 3);
    chk("ooo_rd", Issue_Rd_Tag, 31);
    sb.push_back(mk(4'h8, 5'd3, 32'd1, 32'd2, 6'd31));
    Issue_Ready = 1'b1;
    tick();
    chk("ooo_count", IssueQue_Count, 1);
    chk("ooo_old_waits", Issue_Valid, 0);
    Cdb_Valid = 1'b1; Cdb_Tag = 6'd12; Cdb_Data = 32'h99;
    sb.push_back(mk(4'h9, 5'd0, 32'h99, 32'h40, 6'd30));
    tick();
    Cdb_Valid = 1'b0;
    chk("ooo_old_ready", Issue_Valid, 1);
    tick();
    chk("ooo_count_after", IssueQue_Count, 0);

    // Asynchronous reset with entries present
    Issue_Ready = 1'b0;
    disp(4'h1, 5'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 6'd40);
    disp(4'h1, 5'd0, 1'b1, 32'd2, 6'd0, 1'b1, 32'd2, 6'd0, 6'd41);
    disp(4'h1, 5'd0, 1'b1, 32'd3, 6'd0, 1'b1, 32'd3, 6'd0, 6'd42);
    chk("pre_reset_count", IssueQue_Count, 3);
    #2;
    Resetb = 1'b0;
    #1;
    chk("async_valid", Issue_Valid, 0);
    chk("async_full", IssueQue_Full, 0);
    chk("async_count", IssueQue_Count, 0);
    chk("async_opcode", Issue_Opcode, 0);
    Issue_Ready = 1'b1;
    tick();
    Resetb = 1'b1;
    tick(); tick();
    chk("post_reset_valid", Issue_Valid, 0);
    chk("post_reset_count", IssueQue_Count, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
